// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// Pipelined RISC-V immediate generator for the stage-1 decode path.
// The opcode of each accepted instruction is decoded into its format, and the
// immediate is sign- or zero-extended to XLEN. The result then travels through
// STAGES register stages under a valid/ready handshake. Bubbles collapse, so a
// partly empty pipe keeps absorbing entries while the output is stalled.
//
// Ports:
//   Clock        rising-edge clock
//   Reset_n      asynchronous active-low reset
//   flush        drops every in-flight entry and refuses the current input
//   in_valid     in_inst is valid
//   in_ready     block accepts in_inst this cycle (combinational through the pipe)
//   in_inst      32-bit instruction word
//   out_valid    out_* fields are valid (last stage valid bit)
//   out_ready    consumer accepts the output this cycle
//   out_imm      XLEN-wide extended immediate
//   out_fmt      0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal
//   out_illegal  unrecognised opcode
//   out_inst     instruction carried alongside the result
//   illegal_cnt  saturating count of illegal outputs handed to the consumer
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_inst,
    output logic [15:0]     illegal_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_Z   = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } dec_t;

    // Every format is first assembled as a 32-bit two's-complement value; the
    // final step widens it to XLEN, replicating bit 31 when XLEN is 64.
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d.imm     = {XLEN{1'b0}};
        d.fmt     = FMT_R;
        d.illegal = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                d.imm = sext32({{20{inst[31]}}, inst[31:20]});
                d.fmt = FMT_I;
            end
            7'b1110011: begin
                // funct3[2] separates the CSR immediate forms (zimm in rs1) from the register forms
                if (inst[14]) begin
                    d.imm = XLEN'(inst[19:15]);
                    d.fmt = FMT_Z;
                end else begin
                    d.imm = sext32({{20{inst[31]}}, inst[31:20]});
                    d.fmt = FMT_I;
                end
            end
            7'b0100011: begin
                d.imm = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
                d.fmt = FMT_S;
            end
            7'b1100011: begin
                d.imm = sext32({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
                d.fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                d.imm = sext32({inst[31:12], 12'h000});
                d.fmt = FMT_U;
            end
            7'b1101111: begin
                d.imm = sext32({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
                d.fmt = FMT_J;
            end
            7'b0110011: begin
                d.imm = {XLEN{1'b0}};
                d.fmt = FMT_R;
            end
            default: begin
                d.imm     = {XLEN{1'b0}};
                d.fmt     = FMT_ILL;
                d.illegal = 1'b1;
            end
        endcase
        return d;
    endfunction

    logic [STAGES-1:0] vld_r;
    dec_t              dec_r  [STAGES];
    logic [31:0]       inst_r [STAGES];
    logic [STAGES-1:0] ld_s;
    logic              push_s;
    dec_t              dec_in_s;

    assign dec_in_s = decode(in_inst);

    // Stage-load enables: a stage loads when it is empty or its successor loads.
    // The accumulator walks from the output back to stage 0, so ld_s[k] is
    // out_ready OR any empty stage at index >= k.
    always_comb begin
        logic acc_s;
        ld_s  = {STAGES{1'b0}};
        acc_s = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc_s   = acc_s | ~vld_r[k];
            ld_s[k] = acc_s;
        end
    end

    assign in_ready = ~flush & ld_s[0];
    assign push_s   = in_valid & in_ready;

    // Pipeline registers: flush clears only the valid bits, and payloads move only with valid entries.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                dec_r[k]  <= '0;
                inst_r[k] <= 32'h0000_0000;
            end
        end else if (flush) begin
            vld_r <= {STAGES{1'b0}};
        end else begin
            if (ld_s[0]) begin
                vld_r[0] <= push_s;
                if (push_s) begin
                    dec_r[0]  <= dec_in_s;
                    inst_r[0] <= in_inst;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (ld_s[k]) begin
                    vld_r[k] <= vld_r[k-1];
                    if (vld_r[k-1]) begin
                        dec_r[k]  <= dec_r[k-1];
                        inst_r[k] <= inst_r[k-1];
                    end
                end
            end
        end
    end

    // Saturating illegal counter; an output handshake in a flush cycle still counts.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            illegal_cnt <= 16'h0000;
        end else if (out_valid && out_ready && out_illegal && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'h0001;
        end
    end

    assign out_valid   = vld_r[STAGES-1];
    assign out_imm     = dec_r[STAGES-1].imm;
    assign out_fmt     = dec_r[STAGES-1].fmt;
    assign out_illegal = dec_r[STAGES-1].illegal;
    assign out_inst    = inst_r[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: instance A (XLEN=32, STAGES=2) and instance B
// (XLEN=64, STAGES=3). A reference decoder pushes expected results into a
// queue on each accepted input; monitors pop and compare on each output handshake.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst_n, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
    logic [31:0] a_in_inst, a_out_inst, a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [15:0] a_illegal_cnt;

    logic        b_rst_n, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_inst, b_out_inst;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [15:0] b_illegal_cnt;

    imm_gen_pipe #(.XLEN(32), .STAGES(2)) u_a (
        .Clock(clk), .Reset_n(a_rst_n), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
        .out_fmt(a_out_fmt), .out_illegal(a_out_illegal), .out_inst(a_out_inst),
        .illegal_cnt(a_illegal_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .STAGES(3)) u_b (
        .Clock(clk), .Reset_n(b_rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
        .out_fmt(b_out_fmt), .out_illegal(b_out_illegal), .out_inst(b_out_inst),
        .illegal_cnt(b_illegal_cnt)
    );

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] inst;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   exp_cnt_a = 0;
    int   exp_cnt_b = 0;
    int   pops_b = 0;

    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic signed [11:0] i12, s12;
        logic signed [12:0] b13;
        logic signed [31:0] u32;
        logic signed [20:0] j21;
        e.imm = 64'd0; e.fmt = 3'd0; e.ill = 1'b0; e.inst = w;
        i12 = w[31:20];
        s12 = {w[31:25], w[11:7]};
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        u32 = {w[31:12], 12'h000};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; e.imm = longint'(i12); end
            7'h73: begin
                if (w[14]) begin e.fmt = 3'd6; e.imm = {59'd0, w[19:15]}; end
                else begin e.fmt = 3'd1; e.imm = longint'(i12); end
            end
            7'h23: begin e.fmt = 3'd2; e.imm = longint'(s12); end
            7'h63: begin e.fmt = 3'd3; e.imm = longint'(b13); end
            7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = longint'(u32); end
            7'h6F: begin e.fmt = 3'd5; e.imm = longint'(j21); end
            7'h33: begin e.fmt = 3'd0; e.imm = 64'd0; end
            default: begin e.fmt = 3'd7; e.ill = 1'b1; e.imm = 64'd0; end
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor A: counter tracking and scoreboard pop/push, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_rst_n) begin
            check("a_cnt", a_illegal_cnt, exp_cnt_a);
            if (a_out_valid && a_out_ready) begin
                check("a_sb_nonempty", qa.size() > 0, 1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    check("a_imm", a_out_imm, ea.imm[31:0]);
                    check("a_fmt", a_out_fmt, ea.fmt);
                    check("a_ill", a_out_illegal, ea.ill);
                    check("a_inst", a_out_inst, ea.inst);
                    if (ea.ill && exp_cnt_a < 65535) exp_cnt_a++;
                end
            end
            if (a_flush) qa.delete();
            if (a_in_valid && a_in_ready) qa.push_back(model(a_in_inst));
        end
    end

    logic        hold_b = 1'b0;
    logic [63:0] h_imm;
    logic [2:0]  h_fmt;
    logic        h_ill;
    logic [31:0] h_inst;

    // Monitor B: as A, plus stability of out_* across stalled cycles.
    always @(negedge clk) begin
        if (b_rst_n) begin
            check("b_cnt", b_illegal_cnt, exp_cnt_b);
            if (hold_b) begin
                check("b_hold_valid", b_out_valid, 1);
                check("b_hold_imm", b_out_imm, h_imm);
                check("b_hold_fmt", b_out_fmt, h_fmt);
                check("b_hold_ill", b_out_illegal, h_ill);
                check("b_hold_inst", b_out_inst, h_inst);
            end
            hold_b = b_out_valid && !b_out_ready && !b_flush;
            h_imm = b_out_imm; h_fmt = b_out_fmt; h_ill = b_out_illegal; h_inst = b_out_inst;
            if (b_out_valid && b_out_ready) begin
                check("b_sb_nonempty", qb.size() > 0, 1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    pops_b++;
                    check("b_imm", b_out_imm, eb.imm);
                    check("b_fmt", b_out_fmt, eb.fmt);
                    check("b_ill", b_out_illegal, eb.ill);
                    check("b_inst", b_out_inst, eb.inst);
                    if (eb.ill && exp_cnt_b < 65535) exp_cnt_b++;
                end
            end
            if (b_flush) qb.delete();
            if (b_in_valid && b_in_ready) qb.push_back(model(b_in_inst));
        end else begin
            hold_b = 1'b0;
        end
    end

    // A single accept on A (2 stages), then the result is checked against constants.
    task automatic send_a(input logic [31:0] inst, input logic [31:0] eimm, input logic [2:0] efmt, input logic eill);
        a_in_valid = 1'b1; a_in_inst = inst;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        check("sa_valid", a_out_valid, 1);
        check("sa_imm", a_out_imm, eimm);
        check("sa_fmt", a_out_fmt, efmt);
        check("sa_ill", a_out_illegal, eill);
    endtask

    // A single accept on B (3 stages), then the result is checked against constants.
    task automatic send_b(input logic [31:0] inst, input logic [63:0] eimm, input logic [2:0] efmt);
        b_in_valid = 1'b1; b_in_inst = inst;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("sb_valid", b_out_valid, 1);
        check("sb_imm", b_out_imm, eimm);
        check("sb_fmt", b_out_fmt, efmt);
    endtask

    logic [31:0] sv [4] = '{32'hFFF00093, 32'h00112623, 32'hFE000EE3, 32'h001000EF};
    logic [31:0] si [4] = '{32'hFFFFFFFF, 32'h0000000C, 32'hFFFFFFFC, 32'h00000800};
    logic [2:0]  sf [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [31:0] bp [6] = '{32'h00100093, 32'h00200113, 32'h00312023,
                            32'h0040006F, 32'h00000463, 32'hABCDE137};

    initial begin
        int idx;
        int p0;
        logic saw;
        a_rst_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_in_inst = 32'd0; a_out_ready = 1'b1;
        b_rst_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_inst = 32'd0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_imm", a_out_imm, 0);
        check("rst_a_fmt", a_out_fmt, 0);
        check("rst_a_ill", a_out_illegal, 0);
        check("rst_a_inst", a_out_inst, 0);
        check("rst_a_cnt", a_illegal_cnt, 0);
        check("rst_a_ready", a_in_ready, 1);
        check("rst_b_valid", b_out_valid, 0);
        check("rst_b_imm", b_out_imm, 0);
        check("rst_b_ready", b_in_ready, 1);
        @(posedge clk); #1;

        // Back-to-back stream on A: outputs appear one per cycle after the pipe latency.
        for (int i = 0; i < 6; i++) begin
            a_in_valid = (i < 4);
            a_in_inst  = sv[i % 4];
            @(negedge clk);
            if (i < 2) begin
                check("stream_lat_valid", a_out_valid, 0);
            end else begin
                check("stream_valid", a_out_valid, 1);
                check("stream_imm", a_out_imm, si[i-2]);
                check("stream_fmt", a_out_fmt, sf[i-2]);
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;

        send_a(32'h123450B7, 32'h12345000, 3'd4, 1'b0);
        send_a(32'h300FD073, 32'h0000001F, 3'd6, 1'b0);
        send_a(32'h00B50533, 32'h00000000, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) send_a(32'h0000007F, 32'h00000000, 3'd7, 1'b1);
        @(posedge clk); #1;
        check("cnt_three", a_illegal_cnt, 3);

        // Output handshake coinciding with flush still counts.
        send_a(32'h0000007F, 32'h00000000, 3'd7, 1'b1);
        a_flush = 1'b1;
        #1;
        check("flush_a_ready", a_in_ready, 0);
        @(posedge clk); #1;
        a_flush = 1'b0;
        check("flush_a_cnt", a_illegal_cnt, 4);
        check("flush_a_valid", a_out_valid, 0);

        // Long illegal run to saturate the counter.
        a_in_valid = 1'b1; a_in_inst = 32'h0000007F;
        repeat (65540) @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_saturated", a_illegal_cnt, 16'hFFFF);

        // Asynchronous reset in the middle of a stream.
        a_in_valid = 1'b1; a_in_inst = 32'h00500093;
        repeat (2) @(posedge clk);
        #3;
        a_rst_n = 1'b0; a_in_valid = 1'b0;
        qa.delete(); exp_cnt_a = 0;
        #1;
        check("arst_valid", a_out_valid, 0);
        check("arst_imm", a_out_imm, 0);
        check("arst_fmt", a_out_fmt, 0);
        check("arst_inst", a_out_inst, 0);
        check("arst_cnt", a_illegal_cnt, 0);
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        #1;
        check("arst_release_ready", a_in_ready, 1);
        @(posedge clk); #1;
        send_a(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        @(posedge clk); #1;

        // 64-bit extension on B.
        send_b(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
        send_b(32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1);
        @(posedge clk); #1;

        // Backpressure on B: out_ready low for 4 cycles mid-stream.
        idx = 0; saw = 1'b0; p0 = pops_b;
        for (int c = 0; c < 40; c++) begin
            b_out_ready = !(c >= 3 && c < 7);
            b_in_valid  = (idx < 6);
            b_in_inst   = (idx < 6) ? bp[idx] : 32'd0;
            #1;
            check("bp_in_ready", b_in_ready, (qb.size() < 3) || b_out_ready);
            if (!b_in_ready) saw = 1'b1;
            if (b_in_valid && b_in_ready) idx++;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        check("bp_ready_fell", saw, 1);
        check("bp_all_out", pops_b - p0, 6);
        check("bp_drained", qb.size(), 0);

        // Flush on B with two entries in flight and an offered input.
        b_in_valid = 1'b1; b_in_inst = 32'h00700093;
        @(posedge clk); #1;
        b_in_inst = 32'h00800093;
        @(posedge clk); #1;
        b_flush = 1'b1; b_in_inst = 32'h00900093;
        #1;
        check("flush_b_ready", b_in_ready, 0);
        @(posedge clk); #1;
        b_flush = 1'b0; b_in_inst = 32'h00A00093;
        check("flush_b_valid", b_out_valid, 0);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        check("flush_b_gap1", b_out_valid, 0);
        @(posedge clk); #1;
        check("flush_b_gap2", b_out_valid, 0);
        @(posedge clk); #1;
        check("flush_b_next_valid", b_out_valid, 1);
        check("flush_b_next_inst", b_out_inst, 32'h00A00093);
        repeat (2) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
